// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit sitting directly in front of the data memory.
// One request at a time, with a valid/ready handshake on both the request and
// the response side.
//
// Stores: the byte address becomes a DMEM word index, a byte lane (tail), an
// access type and the write data. DMEM does the byte/half merge itself.
// Loads:  the word DMEM returns is sampled, the addressed lane is picked out,
//         and the result is sign- or zero-extended.
// Misaligned, out-of-window and illegal-size requests come back as faults and
// never reach memory.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid/resp_ready         response handshake
//   resp_rdata, resp_fault        load data (0 for stores/faults), fault code
//   mem_wena, mem_addr, mem_in_type, mem_addr_tail,
//   mem_data32/16/8               registered DMEM command
//   mem_rdata                     DMEM combinational read word
//
// state | meaning
// IDLE  | ready for a request
// STORE | mem_wena high, DMEM writes on the edge leaving this state
// LOAD  | DMEM addressed, mem_rdata sampled on the edge leaving this state
// RESP  | response held until resp_ready
module dmem_lsu #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic        mem_wena,
  output logic [10:0] mem_addr,
  output logic [1:0]  mem_in_type,
  output logic [1:0]  mem_addr_tail,
  output logic [31:0] mem_data32,
  output logic [15:0] mem_data16,
  output logic [7:0]  mem_data8,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STORE = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH_WORDS);

  logic [1:0]  state;
  logic        ld_unsigned;
  logic        accept;
  logic [31:0] off;
  logic [1:0]  acc_fault;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] ld_ext;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign accept     = req_valid & req_ready;

  // Wrapping subtract: addresses below BASE_ADDR land far above the window.
  assign off = req_addr - BASE_ADDR;

  always_comb begin
    acc_fault = 2'b00;
    if (req_size == 2'b11)
      acc_fault = 2'b11;
    else if ((req_size == 2'b01 && req_addr[0]) ||
             (req_size == 2'b00 && req_addr[1:0] != 2'b00))
      acc_fault = 2'b01;
    else if (off >= WIN_BYTES)
      acc_fault = 2'b10;
  end

  // Lane extraction uses the registered tail/type, which are stable in LOAD.
  always_comb begin
    half_sel = mem_addr_tail[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (mem_addr_tail)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    case (mem_in_type)
      2'b01:   ld_ext = ld_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      2'b10:   ld_ext = ld_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ld_unsigned   <= 1'b0;
      resp_rdata    <= 32'h0;
      resp_fault    <= 2'b00;
      mem_wena      <= 1'b0;
      mem_addr      <= 11'h0;
      mem_in_type   <= 2'b00;
      mem_addr_tail <= 2'b00;
      mem_data32    <= 32'h0;
      mem_data16    <= 16'h0;
      mem_data8     <= 8'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (acc_fault != 2'b00) begin
              // mem_* keep their previous values: a fault never addresses DMEM.
              resp_fault <= acc_fault;
              resp_rdata <= 32'h0;
              state      <= S_RESP;
            end else begin
              resp_fault    <= 2'b00;
              ld_unsigned   <= req_unsigned;
              mem_addr      <= off[12:2];
              mem_addr_tail <= off[1:0];
              mem_in_type   <= req_size;
              mem_data32    <= req_wdata;
              mem_data16    <= req_wdata[15:0];
              mem_data8     <= req_wdata[7:0];
              mem_wena      <= req_we;
              state         <= req_we ? S_STORE : S_LOAD;
            end
          end
        end
        S_STORE: begin
          mem_wena   <= 1'b0;
          resp_rdata <= 32'h0;
          state      <= S_RESP;
        end
        S_LOAD: begin
          resp_rdata <= ld_ext;
          state      <= S_RESP;
        end
        default: begin
          if (resp_ready) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic        mem_wena;
  logic [10:0] mem_addr;
  logic [1:0]  mem_in_type;
  logic [1:0]  mem_addr_tail;
  logic [31:0] mem_data32;
  logic [15:0] mem_data16;
  logic [7:0]  mem_data8;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] dmem [0:31] = '{default: 32'h0};

  int          wena_cnt = 0;
  logic [10:0] w_addr;
  logic [1:0]  w_type;
  logic [1:0]  w_tail;
  logic [31:0] w_d32;
  logic [7:0]  w_d8;

  dmem_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_wena(mem_wena), .mem_addr(mem_addr), .mem_in_type(mem_in_type),
    .mem_addr_tail(mem_addr_tail), .mem_data32(mem_data32),
    .mem_data16(mem_data16), .mem_data8(mem_data8), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // DMEM model: combinational read, merged write on the rising edge.
  assign mem_rdata = dmem[mem_addr[4:0]];

  always @(posedge clk) begin
    if (mem_wena) begin
      case (mem_in_type)
        2'b00: dmem[mem_addr[4:0]] <= mem_data32;
        2'b01: begin
          if (mem_addr_tail[1]) dmem[mem_addr[4:0]][31:16] <= mem_data16;
          else                  dmem[mem_addr[4:0]][15:0]  <= mem_data16;
        end
        2'b10: dmem[mem_addr[4:0]][mem_addr_tail*8 +: 8] <= mem_data8;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mem_wena) begin
      wena_cnt++;
      w_addr = mem_addr;
      w_type = mem_in_type;
      w_tail = mem_addr_tail;
      w_d32  = mem_data32;
      w_d8   = mem_data8;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1);
  end

  // Drives one request with resp_ready=1, returns response fields and the
  // number of edges from the accept edge until resp_valid was seen.
  task automatic issue(input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic [1:0] flt,
                       output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = resp_rdata;
    flt = resp_fault;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({req_ready, resp_valid, mem_wena} !== 3'b100) begin
      bad++; $display("FAIL reset_handshake got=%b want=100", {req_ready, resp_valid, mem_wena});
    end
    total++;
    if ({resp_rdata, resp_fault} !== 34'h0) begin
      bad++; $display("FAIL reset_resp got=%h/%b want=0/00", resp_rdata, resp_fault);
    end
    total++;
    if ({mem_addr, mem_in_type, mem_addr_tail} !== 15'h0) begin
      bad++; $display("FAIL reset_mem_addr got=%h/%b/%b want=0", mem_addr, mem_in_type, mem_addr_tail);
    end
    total++;
    if ({mem_data32, mem_data16, mem_data8} !== 56'h0) begin
      bad++; $display("FAIL reset_mem_data got=%h/%h/%h want=0", mem_data32, mem_data16, mem_data8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd; logic [1:0] flt; int lat; int c0;
    c0 = wena_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF, rd, flt, lat);
    total++;
    if (wena_cnt - c0 != 1) begin
      bad++; $display("FAIL sw_wena_pulses got=%0d want=1", wena_cnt - c0);
    end
    total++;
    if ({w_addr, w_type, w_d32} !== {11'd2, 2'b00, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL sw_mem_cmd got=%0d/%b/%h want=2/00/deadbeef", w_addr, w_type, w_d32);
    end
    total++;
    if ({rd, flt, lat} !== {32'h0, 2'b00, 32'd2}) begin
      bad++; $display("FAIL sw_resp got=%h/%b/%0d want=0/00/2", rd, flt, lat);
    end
    total++;
    if (dmem[2] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL sw_dmem got=%h want=deadbeef", dmem[2]);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h1001_0008, 32'h0, rd, flt, lat);
    total++;
    if ({rd, flt, lat} !== {32'hDEAD_BEEF, 2'b00, 32'd2}) begin
      bad++; $display("FAIL lw_resp got=%h/%b/%0d want=deadbeef/00/2", rd, flt, lat);
    end
    // Last word in the window.
    issue(1'b1, 2'b00, 1'b0, 32'h1001_007C, 32'hCAFE_F00D, rd, flt, lat);
    total++;
    if (w_addr !== 11'd31) begin
      bad++; $display("FAIL sw_top_addr got=%0d want=31", w_addr);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h1001_007C, 32'h0, rd, flt, lat);
    total++;
    if ({rd, flt} !== {32'hCAFE_F00D, 2'b00}) begin
      bad++; $display("FAIL lw_top got=%h/%b want=cafef00d/00", rd, flt);
    end
  endtask

  task automatic test_extension();
    logic [1:0]  sz  [4] = '{2'b10, 2'b10, 2'b01, 2'b01};
    logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad  [4] = '{32'h1001_000B, 32'h1001_000B, 32'h1001_000A, 32'h1001_0008};
    logic [31:0] exp [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
    logic [31:0] rd; logic [1:0] flt; int lat;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, sz[i], un[i], ad[i], 32'h0, rd, flt, lat);
      total++;
      if ({rd, flt} !== {exp[i], 2'b00}) begin
        bad++; $display("FAIL ext_load%0d got=%h/%b want=%h/00", i, rd, flt, exp[i]);
      end
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd; logic [1:0] flt; int lat;
    issue(1'b1, 2'b10, 1'b0, 32'h1001_0009, 32'h0000_0012, rd, flt, lat);
    total++;
    if ({w_type, w_tail, w_d8} !== {2'b10, 2'b01, 8'h12}) begin
      bad++; $display("FAIL sb_mem_cmd got=%b/%b/%h want=10/01/12", w_type, w_tail, w_d8);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h1001_0008, 32'h0, rd, flt, lat);
    total++;
    if (rd !== 32'hDEAD_12EF) begin
      bad++; $display("FAIL sb_readback got=%h want=dead12ef", rd);
    end
  endtask

  task automatic test_faults();
    logic        we  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sz  [5] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b11};
    logic [31:0] ad  [5] = '{32'h1001_0006, 32'h1001_0081, 32'h1001_0080,
                             32'h1000_FFFC, 32'h1001_0008};
    logic [1:0]  exf [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [31:0] rd; logic [1:0] flt; int lat; int c0;
    for (int i = 0; i < 5; i++) begin
      c0 = wena_cnt;
      issue(we[i], sz[i], 1'b0, ad[i], 32'h5A5A_5A5A, rd, flt, lat);
      total++;
      if ({flt, rd, lat, wena_cnt - c0} !== {exf[i], 32'h0, 32'd1, 32'd0}) begin
        bad++; $display("FAIL fault%0d got=%b/%h/lat%0d/wena%0d want=%b/0/lat1/wena0",
                        i, flt, rd, lat, wena_cnt - c0, exf[i]);
      end
    end
    total++;
    if (dmem[2] !== 32'hDEAD_12EF) begin
      bad++; $display("FAIL fault_dmem got=%h want=dead12ef", dmem[2]);
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h1001_0008; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({resp_valid, req_ready, resp_rdata} !== {1'b1, 1'b0, 32'hDEAD_12EF}) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%b/%h want=1/0/dead12ef",
                        i, resp_valid, req_ready, resp_rdata);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      bad++; $display("FAIL bp_release got=%b%b want=01", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    total++;
    if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_single got=%b want=0", resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int rsp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h1001_0008; resp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (req_ready === 1'b1) acc++;
      if (resp_valid === 1'b1) begin
        rsp++;
        total++;
        if (resp_rdata !== 32'hDEAD_12EF) begin
          bad++; $display("FAIL b2b_data got=%h want=dead12ef", resp_rdata);
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    total++;
    if (acc != 3 || rsp != 3) begin
      bad++; $display("FAIL b2b_rate got=acc%0d/rsp%0d want=acc3/rsp3", acc, rsp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_store();
    int c0;
    c0 = wena_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h1001_0008; req_wdata = 32'h5555_5555; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (mem_wena !== 1'b1) begin
      bad++; $display("FAIL rst_store_enter got=%b want=1", mem_wena);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_wena !== 1'b0) begin
      bad++; $display("FAIL rst_wena_async got=%b want=0", mem_wena);
    end
    @(posedge clk); #1;
    total++;
    if (dmem[2] !== 32'hDEAD_12EF || wena_cnt != c0) begin
      bad++; $display("FAIL rst_dmem got=%h/wena%0d want=dead12ef/wena0", dmem[2], wena_cnt - c0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      bad++; $display("FAIL rst_release got=%b%b want=10", req_ready, resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_extension();
    test_subword_store();
    test_faults();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
